sextium_io_buffer: RTL
======================

SEXTIUM_IO_BUFFER -- requirements
Module: sextium_io_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entries per FIFO; power of two, at least 2.
REQ-002 SHALL have parameter WORD_W, default 16, data word width.
REQ-003 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous, active-high.
REQ-005 SHALL have port io_read, input, 1, core read request.
REQ-006 SHALL have port io_write, input, 1, core write request.
REQ-007 SHALL have port ioack, output, 1, four-phase acknowledge to core.
REQ-008 SHALL have port io_bus, inout, WORD_W, shared core I/O data bus.
REQ-009 SHALL have port in_data, input, WORD_W, external input word.
REQ-010 SHALL have port in_valid / in_ready, input / output, 1 each, external input handshake.
REQ-011 SHALL have port out_data, output, WORD_W, external output word.
REQ-012 SHALL have port out_valid / out_ready, output / input, 1 each, external output handshake.
REQ-013 SHALL have port proto_err, output, 1, sticky protocol-error flag.

Function
REQ-014 SHALL contain an RX FIFO (external to core) and a TX FIFO (core to external), each DEPTH x WORD_W.
REQ-015 SHALL push RX on any clock edge where in_valid and in_ready are both high; in_ready = RX not full.
REQ-016 SHALL present the TX head on out_data with out_valid = TX not empty, and pop TX when out_valid and out_ready are both high.
REQ-017 SHALL run a core-side FSM with states IDLE, RD_ACK, WR_ACK and RELEASE.
REQ-018 IDLE: with io_read=1, io_write=0 and RX not empty, SHALL latch the RX head into a read register, pop RX, and enter RD_ACK on the next edge.
REQ-019 IDLE: with io_write=1, io_read=0 and TX not full, SHALL push io_bus into TX and enter WR_ACK on the next edge.
REQ-020 IDLE: if the requested FIFO is empty (read) or full (write), SHALL stay in IDLE with ioack=0 until space or data appears; the request is then served.
REQ-021 ioack SHALL be registered and high exactly in RD_ACK and WR_ACK.
REQ-022 SHALL drive io_bus with the read register only in RD_ACK while io_read=1; otherwise io_bus is high-Z.
REQ-023 RD_ACK/WR_ACK SHALL move to RELEASE when the matching request falls; RELEASE SHALL return to IDLE on the next edge. A new request is therefore accepted no earlier than 2 cycles after the request drops.
REQ-024 In IDLE with io_read=1 and io_write=1 on the same edge, SHALL serve neither request, set proto_err=1, and hold it set until reset.
REQ-025 Simultaneous core-side and external-side push/pop on the same FIFO SHALL both take effect; pointer wrap SHALL be modulo DEPTH; full and empty SHALL derive from a DEPTH+1-state count.

Reset
REQ-026 Asserting reset at any time SHALL immediately give: FSM=IDLE, ioack=0, io_bus high-Z, both FIFOs empty, out_valid=0, in_ready=1, proto_err=0, read register=0.
REQ-027 A transaction in progress at reset SHALL be abandoned; after reset release the core must raise a fresh request.

Configuration
REQ-028 When macro SEXTIUM_IO_LOOPBACK_EN is defined, the TX head SHALL feed the RX push port internally: transfer occurs when TX is not empty and RX is not full, one word per cycle. In this mode out_valid=0, in_ready=0, and in_data/out_ready are ignored.
REQ-029 When SEXTIUM_IO_LOOPBACK_EN is undefined, external ports SHALL behave per REQ-015/016 and no loopback logic SHALL exist.

Structure
REQ-030 Package sextium_io_pkg SHALL hold the FSM state enum typedef and the WORD_W default constant.
REQ-031 The FIFO SHALL be a sub-module sextium_io_fifo (parameters DEPTH and WORD_W; ports push, pop, din, dout, full, empty), instantiated twice.

Verification
REQ-032 Test 1: in_data=16'h1234 pushed; core io_read -> ioack rises 1 cycle later with io_bus=16'h1234; drop io_read -> ioack=0 next edge; RX empty.
REQ-033 Test 2: core writes 16'hBEEF with out_ready=0 -> ioack=1, out_valid=1, out_data=16'hBEEF held; out_ready=1 -> out_valid=0 next cycle.
REQ-034 Test 3: 5 core writes with out_ready=0 and DEPTH=4 -> 4 acked; 5th ioack stays 0 until one out_ready pulse, then acked with no lost data.
REQ-035 Test 4: io_read and io_write raised together in IDLE -> no ioack, proto_err=1 and sticky, FIFO contents unchanged.
REQ-036 Test 5: reset asserted during RD_ACK -> ioack=0 and io_bus high-Z asynchronously; FIFOs empty after release.
REQ-037 Test 6 (SEXTIUM_IO_LOOPBACK_EN): core writes 16'h0042 then reads -> read returns 16'h0042; out_valid remains 0.

Source files
------------

// File: rtl/sextium_io_pkg.sv
// Shared types and constants for the Sextium I/O buffer: the core-side FSM
// state encoding and the default data word width.
package sextium_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_ACK  = 2'd1,
    ST_WR_ACK  = 2'd2,
    ST_RELEASE = 2'd3
  } io_state_e;

  localparam int WORD_W_DEF = 16;

endpackage

// File: rtl/sextium_io_buffer_if.sv
// External stream side of the Sextium I/O buffer: the input word and output word
// valid/ready pairs. The master modport is the external agent and the slave modport is the buffer.
// valid/ready: a word transfers on a rising clock edge where both are high. valid
// must not wait for ready, and data stays stable while valid is high and ready is low.
interface sextium_io_buffer_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/sextium_io_fifo.sv
// Single-clock FIFO with DEPTH entries of WORD_W bits. Full and empty come from a
// DEPTH+1-state occupancy count. A push and a pop in the same cycle both take effect.
module sextium_io_fifo #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rptr_q];

    // DEPTH is a power of two, so the pointers wrap modulo DEPTH on their own.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q] <= din;
    end
endmodule

// File: rtl/sextium_io_buffer.sv
// Sextium core I/O buffer: an RX FIFO and a TX FIFO between the core's four-phase
// io_read/io_write/ioack bus and an external valid/ready stream. If the macro
// SEXTIUM_IO_LOOPBACK_EN is defined, the TX head feeds RX internally.
module sextium_io_buffer
  import sextium_io_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_read,
    input  logic              io_write,
    output logic              ioack,
    inout  wire  [WORD_W-1:0] io_bus,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              proto_err
);
    io_state_e         state_q;
    logic              ioack_q;
    logic              proto_err_q;
    logic [WORD_W-1:0] rd_q;

    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [WORD_W-1:0] rx_din, rx_dout;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [WORD_W-1:0] tx_dout;
    logic              bus_drive;

    // Core-side FIFO strobes decode from the current state and request, so the
    // push or pop lands on the same edge that enters the ACK state.
    assign rx_pop  = (state_q == ST_IDLE) && io_read && !io_write && !rx_empty;
    assign tx_push = (state_q == ST_IDLE) && io_write && !io_read && !tx_full;

    assign bus_drive = (state_q == ST_RD_ACK) && io_read;
    assign io_bus    = bus_drive ? rd_q : 'z;
    assign ioack     = ioack_q;
    assign proto_err = proto_err_q;

`ifdef SEXTIUM_IO_LOOPBACK_EN
    logic lb_xfer;
    logic unused_ext;
    assign lb_xfer    = !tx_empty && !rx_full;
    assign rx_push    = lb_xfer;
    assign rx_din     = tx_dout;
    assign tx_pop     = lb_xfer;
    assign in_ready   = 1'b0;
    assign out_valid  = 1'b0;
    assign out_data   = '0;
    assign unused_ext = ^{in_data, in_valid, out_ready};
`else
    assign rx_push   = in_valid && !rx_full;
    assign rx_din    = in_data;
    assign in_ready  = !rx_full;
    assign out_valid = !tx_empty;
    assign out_data  = tx_dout;
    assign tx_pop    = out_ready && !tx_empty;
`endif

    sextium_io_fifo #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_rx (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_din),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    sextium_io_fifo #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_tx (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (io_bus),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ioack_q     <= 1'b0;
            proto_err_q <= 1'b0;
            rd_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (io_read && io_write) begin
                        proto_err_q <= 1'b1;
                    end else if (rx_pop) begin
                        rd_q    <= rx_dout;
                        ioack_q <= 1'b1;
                        state_q <= ST_RD_ACK;
                    end else if (tx_push) begin
                        ioack_q <= 1'b1;
                        state_q <= ST_WR_ACK;
                    end
                end
                ST_RD_ACK: begin
                    if (!io_read) begin
                        ioack_q <= 1'b0;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_WR_ACK: begin
                    if (!io_write) begin
                        ioack_q <= 1'b0;
                        state_q <= ST_RELEASE;
                    end
                end
                default: begin
                    ioack_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
